// File: rtl/tail_light_pattern_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : tail_light_pattern_monitor_if
// Brief    : Lamp-bus observation lines and diagnostics outputs of the
//            tail-light pattern monitor.
// Revision : 1.0
// ============================================================================
interface tail_light_pattern_monitor_if;
  logic       LA, LB, LC, RA, RB, RC;
  logic       clr_err;
  logic [1:0] mode;
  logic       mode_valid;
  logic [1:0] step;
  logic       cycle_done;
  logic       err_seq;
  logic       err_timing;
  logic       err_illegal;
  logic       err_sticky;

  modport master (
    output LA, LB, LC, RA, RB, RC, clr_err,
    input  mode, mode_valid, step, cycle_done,
           err_seq, err_timing, err_illegal, err_sticky
  );

  modport slave (
    input  LA, LB, LC, RA, RB, RC, clr_err,
    output mode, mode_valid, step, cycle_done,
           err_seq, err_timing, err_illegal, err_sticky
  );
endinterface
`default_nettype wire

// File: rtl/tail_light_pattern_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tail_light_pattern_monitor
// Brief    : Decodes T-bird tail-light lamp patterns back into the commanded
//            mode and checks sequence legality and per-pattern dwell time.
// Revision : 1.0
// ============================================================================
module tail_light_pattern_monitor #(
  parameter real STATE_TIME   = 0.6667,
  parameter real CLOCK_PERIOD = 2000.0,
  parameter int  TOL_CYCLES   = 2
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  tail_light_pattern_monitor_if.slave bus
);

  localparam int DWELL_COUNT = int'(STATE_TIME * 1.0e9 / CLOCK_PERIOD);
  localparam int CW          = $clog2(DWELL_COUNT + TOL_CYCLES + 2);

  localparam logic [CW-1:0] c_DWELL_MIN = CW'(DWELL_COUNT - TOL_CYCLES);
  localparam logic [CW-1:0] c_DWELL_MAX = CW'(DWELL_COUNT + TOL_CYCLES);
  localparam logic [CW-1:0] c_CNT_SAT   = {CW{1'b1}};

  // Lamp vector order is {LC,LB,LA,RA,RB,RC}
  localparam logic [5:0] c_PAT_OFF = 6'b000000;
  localparam logic [5:0] c_PAT_L1  = 6'b001000;
  localparam logic [5:0] c_PAT_L2  = 6'b011000;
  localparam logic [5:0] c_PAT_L3  = 6'b111000;
  localparam logic [5:0] c_PAT_R1  = 6'b000100;
  localparam logic [5:0] c_PAT_R2  = 6'b000110;
  localparam logic [5:0] c_PAT_R3  = 6'b000111;
  localparam logic [5:0] c_PAT_HZ  = 6'b111111;

  typedef enum logic [3:0] {
    S_START  = 4'd0,
    S_OFF    = 4'd1,
    S_L1     = 4'd2,
    S_L2     = 4'd3,
    S_L3     = 4'd4,
    S_R1     = 4'd5,
    S_R2     = 4'd6,
    S_R3     = 4'd7,
    S_HZ     = 4'd8,
    S_RESYNC = 4'd9
  } state_t;

  logic [5:0]    lamp_q, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  state_t        state_q, state_d;
  logic          done_q, done_d;
  logic          seq_q, seq_d;
  logic          timing_q, timing_d;
  logic          illegal_q, illegal_d;
  logic          sticky_q, sticky_d;

  logic          w_change;
  state_t        w_pat_state;
  logic          w_legal;
  logic          w_dwell_bad;
  logic          w_lit;

  assign w_change = (lamp_q != prev_q);
  assign w_lit    = (state_q inside {S_L1, S_L2, S_L3, S_R1, S_R2, S_R3, S_HZ});

  // Patterns outside the legal set classify as RESYNC, i.e. "illegal"
  always_comb begin
    case (lamp_q)
      c_PAT_OFF: w_pat_state = S_OFF;
      c_PAT_L1:  w_pat_state = S_L1;
      c_PAT_L2:  w_pat_state = S_L2;
      c_PAT_L3:  w_pat_state = S_L3;
      c_PAT_R1:  w_pat_state = S_R1;
      c_PAT_R2:  w_pat_state = S_R2;
      c_PAT_R3:  w_pat_state = S_R3;
      c_PAT_HZ:  w_pat_state = S_HZ;
      default:   w_pat_state = S_RESYNC;
    endcase
  end

  always_comb begin
    w_legal = 1'b0;
    case (state_q)
      S_START, S_OFF: w_legal = (w_pat_state inside {S_L1, S_R1, S_HZ});
      S_L1:           w_legal = (w_pat_state inside {S_L2, S_HZ});
      S_L2:           w_legal = (w_pat_state inside {S_L3, S_HZ});
      S_L3:           w_legal = (w_pat_state inside {S_OFF, S_HZ});
      S_R1:           w_legal = (w_pat_state inside {S_R2, S_HZ});
      S_R2:           w_legal = (w_pat_state inside {S_R3, S_HZ});
      S_R3:           w_legal = (w_pat_state inside {S_OFF, S_HZ});
      S_HZ:           w_legal = (w_pat_state == S_OFF);
      default:        w_legal = 1'b0;
    endcase
  end

  // OFF may idle indefinitely, so only its minimum dwell matters
  assign w_dwell_bad = (cnt_q < c_DWELL_MIN) ||
                       ((state_q != S_OFF) && (cnt_q > c_DWELL_MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (w_change)
      cnt_d = {{(CW-1){1'b0}}, 1'b1};
    else if (cnt_q != c_CNT_SAT)
      cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    seq_d     = 1'b0;
    timing_d  = 1'b0;
    illegal_d = 1'b0;
    if (state_q == S_RESYNC) begin
      if (lamp_q == c_PAT_OFF)
        state_d = S_OFF;
    end else if (w_change) begin
      timing_d  = (state_q != S_START) && w_dwell_bad;
      illegal_d = (w_pat_state == S_RESYNC);
      seq_d     = (w_pat_state != S_RESYNC) && !w_legal;
      if (timing_d || illegal_d || seq_d) begin
        state_d = S_RESYNC;
      end else begin
        state_d = w_pat_state;
        done_d  = (w_pat_state == S_OFF);
      end
    end else if (w_lit && (cnt_q == c_DWELL_MAX)) begin
      // Counter is about to reach MAX+1: overstay flagged once, then resync
      timing_d = 1'b1;
      state_d  = S_RESYNC;
    end
  end

  assign sticky_d = (seq_d || timing_d || illegal_d) ? 1'b1 :
                    (bus.clr_err ? 1'b0 : sticky_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lamp_q    <= c_PAT_OFF;
      prev_q    <= c_PAT_OFF;
      cnt_q     <= '0;
      state_q   <= S_START;
      done_q    <= 1'b0;
      seq_q     <= 1'b0;
      timing_q  <= 1'b0;
      illegal_q <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      lamp_q    <= {bus.LC, bus.LB, bus.LA, bus.RA, bus.RB, bus.RC};
      prev_q    <= lamp_q;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      done_q    <= done_d;
      seq_q     <= seq_d;
      timing_q  <= timing_d;
      illegal_q <= illegal_d;
      sticky_q  <= sticky_d;
    end
  end

  always_comb begin
    bus.mode       = 2'b00;
    bus.step       = 2'd0;
    bus.mode_valid = 1'b1;
    case (state_q)
      S_L1:     begin bus.mode = 2'b01; bus.step = 2'd1; end
      S_L2:     begin bus.mode = 2'b01; bus.step = 2'd2; end
      S_L3:     begin bus.mode = 2'b01; bus.step = 2'd3; end
      S_R1:     begin bus.mode = 2'b10; bus.step = 2'd1; end
      S_R2:     begin bus.mode = 2'b10; bus.step = 2'd2; end
      S_R3:     begin bus.mode = 2'b10; bus.step = 2'd3; end
      S_HZ:     begin bus.mode = 2'b11; bus.step = 2'd3; end
      S_RESYNC: bus.mode_valid = 1'b0;
      default:  bus.mode = 2'b00;
    endcase
  end

  assign bus.cycle_done  = done_q;
  assign bus.err_seq     = seq_q;
  assign bus.err_timing  = timing_q;
  assign bus.err_illegal = illegal_q;
  assign bus.err_sticky  = sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_tail_light_pattern_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_tail_light_pattern_monitor
// Brief    : Directed and random lamp sequences against a cycle reference model.
// Revision : 1.0
// ============================================================================
module tb_tail_light_pattern_monitor;

  // 16 us state time at 2 us clock: 8 nominal cycles per pattern
  localparam int D   = 8;
  localparam int T   = 1;
  localparam int SAT = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  tail_light_pattern_monitor_if bus();

  tail_light_pattern_monitor #(
    .STATE_TIME  (16.0e-6),
    .CLOCK_PERIOD(2000.0),
    .TOL_CYCLES  (T)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // index 0 OFF, 1..3 L1..L3, 4..6 R1..R3, 7 HZ
  logic [5:0] pat_tbl [8] = '{6'b000000, 6'b001000, 6'b011000, 6'b111000,
                              6'b000100, 6'b000110, 6'b000111, 6'b111111};

  function automatic int classify(input logic [5:0] p);
    for (int i = 0; i < 8; i++)
      if (pat_tbl[i] == p) return i;
    return -1;
  endfunction

  function automatic bit succ_ok(input int from, input int to);
    if (from == 0)                return (to == 1 || to == 4 || to == 7);
    if (from == 7)                return (to == 0);
    if (to == 7)                  return 1'b1;
    if (from == 3 || from == 6)   return (to == 0);
    return (to == from + 1);
  endfunction

  function automatic logic [1:0] mode_of(input int i);
    if (i == 0) return 2'b00;
    if (i <= 3) return 2'b01;
    if (i <= 6) return 2'b10;
    return 2'b11;
  endfunction

  function automatic logic [1:0] step_of(input int i);
    if (i == 0) return 2'd0;
    if (i <= 3) return 2'(i);
    if (i <= 6) return 2'(i - 3);
    return 2'd3;
  endfunction

  // reference model state
  int         m_cur;
  bit         m_lost, m_start, m_sticky;
  bit         m_done, m_seq, m_tim, m_ill;
  int         m_run;
  logic [5:0] m_last, m_pend;

  int n_done, n_seq, n_tim, n_ill;

  task automatic model_reset();
    m_cur = 0; m_lost = 0; m_start = 1; m_sticky = 0;
    m_done = 0; m_seq = 0; m_tim = 0; m_ill = 0;
    m_run = 0; m_last = '0; m_pend = '0;
  endtask

  task automatic model_edge(input bit clr);
    logic [5:0] r;
    bit chg;
    int old_run, idx;
    r = m_pend;
    m_done = 0; m_seq = 0; m_tim = 0; m_ill = 0;
    chg = (r != m_last);
    old_run = m_run;
    m_run = chg ? 1 : ((m_run < SAT) ? m_run + 1 : SAT);
    m_last = r;
    if (m_lost) begin
      if (r == 6'b000000) begin
        m_lost = 0; m_cur = 0; m_start = 0;
      end
    end else if (chg) begin
      idx = classify(r);
      if (!m_start)
        m_tim = (old_run < D - T) || (m_cur != 0 && old_run > D + T);
      if (idx < 0) m_ill = 1;
      else if (!succ_ok(m_cur, idx)) m_seq = 1;
      if (m_ill || m_seq || m_tim) m_lost = 1;
      else begin
        m_done  = (idx == 0);
        m_cur   = idx;
        m_start = 0;
      end
    end else if (m_cur != 0 && m_run == D + T + 1) begin
      m_tim = 1; m_lost = 1;
    end
    if (m_seq || m_tim || m_ill) m_sticky = 1;
    else if (clr)                m_sticky = 0;
  endtask

  function automatic logic [15:0] dut_vec();
    return {6'd0, bus.mode, bus.step, bus.mode_valid, bus.cycle_done,
            bus.err_seq, bus.err_timing, bus.err_illegal, bus.err_sticky};
  endfunction

  function automatic logic [15:0] exp_vec();
    logic [1:0] md, st;
    md = m_lost ? 2'b00 : mode_of(m_cur);
    st = m_lost ? 2'd0  : step_of(m_cur);
    return {6'd0, md, st, !m_lost, m_done, m_seq, m_tim, m_ill, m_sticky};
  endfunction

  task automatic drive(input logic [5:0] p, input logic clr);
    {bus.LC, bus.LB, bus.LA, bus.RA, bus.RB, bus.RC} = p;
    bus.clr_err = clr;
  endtask

  task automatic cycle(input logic [5:0] p, input logic clr);
    drive(p, clr);
    @(posedge clk);
    model_edge(clr);
    m_pend = p;
    #1;
    check_val("cycle", dut_vec(), exp_vec());
    n_done += int'(bus.cycle_done);
    n_seq  += int'(bus.err_seq);
    n_tim  += int'(bus.err_timing);
    n_ill  += int'(bus.err_illegal);
    @(negedge clk);
  endtask

  task automatic hold(input logic [5:0] p, input int n);
    for (int i = 0; i < n; i++) cycle(p, 1'b0);
  endtask

  task automatic clear_counts();
    n_done = 0; n_seq = 0; n_tim = 0; n_ill = 0;
  endtask

  task automatic do_reset(input logic [5:0] p_after);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("reset", dut_vec(), 16'b0000_0000_0010_0000);
    model_reset();
    drive(p_after, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    drive(6'b000000, 1'b0);
    model_reset();
    clear_counts();
    @(negedge clk);
    do_reset(6'b000000);

    // left sequence
    clear_counts();
    hold(6'b001000, 8); hold(6'b011000, 8); hold(6'b111000, 8); hold(6'b000000, 8);
    check_val("left_done", 16'(n_done), 16'd1);
    check_val("left_errs", 16'(n_seq + n_tim + n_ill), 16'd0);

    // right sequence then hazard
    clear_counts();
    hold(6'b000100, 8); hold(6'b000110, 8); hold(6'b000111, 8); hold(6'b000000, 8);
    hold(6'b111111, 8); hold(6'b000000, 8);
    check_val("rh_done", 16'(n_done), 16'd2);
    check_val("rh_sticky", 16'(bus.err_sticky), 16'd0);

    // illegal jump L1 -> L3
    clear_counts();
    hold(6'b001000, 8); hold(6'b111000, 3);
    check_val("jump_valid", 16'(bus.mode_valid), 16'd0);
    hold(6'b000000, 8);
    check_val("jump_seq", 16'(n_seq), 16'd1);
    check_val("jump_mode", {14'd0, bus.mode}, 16'd0);
    cycle(6'b000000, 1'b1);

    // short L2 dwell, then L1 overstay
    clear_counts();
    hold(6'b001000, 8); hold(6'b011000, 5); hold(6'b000000, 8);
    check_val("short_tim", 16'(n_tim), 16'd1);
    clear_counts();
    hold(6'b001000, 12); hold(6'b000000, 8);
    check_val("long_tim", 16'(n_tim), 16'd1);

    // illegal pattern, then clr_err colliding with a new error
    cycle(6'b000000, 1'b1); hold(6'b000000, 7);
    clear_counts();
    hold(6'b001000, 8); hold(6'b101000, 2); hold(6'b000000, 8);
    check_val("ill_cnt", 16'(n_ill), 16'd1);
    check_val("ill_noseq", 16'(n_seq), 16'd0);
    cycle(6'b000000, 1'b1); hold(6'b000000, 7);
    cycle(6'b101000, 1'b0); cycle(6'b101000, 1'b1);
    check_val("clr_vs_err", 16'(bus.err_sticky), 16'd1);
    hold(6'b000000, 8);

    // reset during L2, immediate L1 afterwards
    hold(6'b001000, 8); hold(6'b011000, 3);
    do_reset(6'b001000);
    clear_counts();
    hold(6'b001000, 8); hold(6'b011000, 8);
    check_val("post_rst_tim", 16'(n_tim), 16'd0);
    check_val("post_rst_step", {14'd0, bus.step}, 16'd2);

    // random walk over mostly-legal sequences
    begin
      int cur_i;
      cur_i = 2;
      for (int it = 0; it < 45; it++) begin
        int r, nxt, n;
        int opts[$];
        logic [5:0] p;
        r = int'($urandom_range(0, 19));
        if (r == 0) begin
          p = 6'($urandom_range(0, 63));
        end else if (r < 3) begin
          nxt = int'($urandom_range(0, 7));
          p = pat_tbl[nxt]; cur_i = nxt;
        end else begin
          opts.delete();
          for (int k = 0; k < 8; k++) if (succ_ok(cur_i, k)) opts.push_back(k);
          nxt = opts[$urandom_range(0, opts.size() - 1)];
          p = pat_tbl[nxt]; cur_i = nxt;
        end
        if ($urandom_range(0, 7) == 0) n = int'($urandom_range(2, 13));
        else                           n = D - T + int'($urandom_range(0, 2 * T));
        for (int c = 0; c < n; c++) cycle(p, $urandom_range(0, 9) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tail_light_pattern_monitor.md
Name: tail_light_pattern_monitor

Overview:
- Receive-side checker for the T-bird tail-light lamp bus.
- Observes the six lamp lines driven by the tail-light controller and decodes them back into the commanded mode: left, right or hazard.
- Checks every pattern transition against the legal sequence and checks each pattern's dwell time against the nominal state period.
- Reports decoded mode, sequence step, completed-cycle pulses and error flags to the diagnostics logic.

Parameters:
- state_time, 0.6667, nominal dwell of each lamp pattern in seconds (real).
- clock_period, 2000, clock period in nanoseconds (real).
- tol_cycles, 2, allowed dwell deviation in clock cycles (int).
- Derived localparam: dwell_count = int'(state_time*1s / (clock_period*1ns)), the nominal cycles per pattern.
- Derived counter width: $clog2(dwell_count + tol_cycles + 2).

Ports:
- clk, input, 1, positive-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- LA, LB, LC, RA, RB, RC, input, 1 each, observed lamp lines.
- clr_err, input, 1, clears err_sticky.
- mode, output, 2, decoded mode: 00 none, 01 left, 10 right, 11 hazard.
- mode_valid, output, 1, mode and step are trustworthy.
- step, output, 2, position in the sequence: 0 off, 1..3 lamps lit; hazard reports 3.
- cycle_done, output, 1, one-cycle pulse when a complete sequence returns to OFF.
- err_seq, output, 1, one-cycle pulse on an illegal transition.
- err_timing, output, 1, one-cycle pulse on a dwell violation.
- err_illegal, output, 1, one-cycle pulse on an undefined lamp pattern.
- err_sticky, output, 1, OR of all errors since the last clr_err or reset.

Behaviour:
- Lamp vector {LC,LB,LA,RA,RB,RC} is registered once, then classified from the registered value.
- Latency: a lamp change sampled at edge N updates all outputs at edge N+1.
- Legal patterns:
  - OFF = 000000.
  - L1 = 001000, L2 = 011000, L3 = 111000.
  - R1 = 000100, R2 = 000110, R3 = 000111.
  - HZ = 111111.
  - Any other pattern is illegal.
- States: START, OFF, L1, L2, L3, R1, R2, R3, HZ, RESYNC.
  - Reset enters START.
  - START behaves as OFF with no minimum dwell check, because the first departure from IDLE after controller reset is immediate.
- Legal transitions:
  - OFF/START -> L1, R1 or HZ.
  - L1 -> L2; L2 -> L3; L3 -> OFF.
  - R1 -> R2; R2 -> R3; R3 -> OFF.
  - L1, L2, L3, R1, R2, R3 -> HZ.
  - HZ -> OFF.
  - Unchanged pattern means stay in the current state.
- Dwell counter:
  - Reset to 1 when the registered pattern changes; otherwise increments and saturates at max.
  - On a change, the outgoing pattern's count must lie in [dwell_count - tol_cycles, dwell_count + tol_cycles]; otherwise pulse err_timing.
  - For OFF, only the lower bound is checked. START has no check.
  - While in L*, R* or HZ, err_timing pulses in the cycle the count reaches dwell_count + tol_cycles + 1. Only one pulse per pattern, then enter RESYNC.
- Errors:
  - Illegal transition: err_seq pulses, enter RESYNC.
  - Illegal pattern: err_illegal pulses, enter RESYNC.
  - If the illegal pattern is also an illegal transition, only err_illegal pulses.
- RESYNC: mode_valid = 0, mode = 00, step = 0. Leave to OFF only when the OFF pattern is observed, with no dwell check on the exit.
- Output values per state:
  - L states: mode = 01, R states: mode = 10, HZ: mode = 11; step follows the state number.
  - OFF/START: mode = 00, step = 0.
  - mode_valid = 1 in every state except RESYNC.
- cycle_done pulses on a legal, in-tolerance L3->OFF, R3->OFF or HZ->OFF.
- A timing error on that same transition suppresses cycle_done and goes to RESYNC, not OFF.
- err_sticky:
  - Set by any error pulse; cleared by clr_err.
  - clr_err in the same cycle as a new error: the error wins and err_sticky stays 1.
- Reset values:
  - Async reset mid-operation forces START immediately and clears the counter and input register.
  - mode = 00, step = 0, mode_valid = 1, all pulses and err_sticky = 0.

Test Plan:
Use state_time = 16e-6, clock_period = 2000, giving dwell_count = 8, with tol_cycles = 1.
- Left sequence: after reset drive 001000, 011000, 111000 for 8 cycles each, then 000000 -> mode 01, step 1/2/3 at one-cycle latency, cycle_done 1-cycle pulse, no errors.
- Right sequence, then hazard: 000100, 000110, 000111 ×8, OFF ×8, then 111111 ×8, then OFF -> mode 10 then 11, two cycle_done pulses, err_sticky 0.
- Illegal jump: 001000 ×8 then 111000 -> err_seq pulse, mode_valid 0 until 000000 is seen, then mode_valid 1 with mode 00.
- Timing: L2 held 5 cycles -> err_timing on change. Separately, L1 held 12 cycles -> err_timing exactly when the count reaches 10, single pulse.
- Illegal pattern 101000 -> err_illegal only (no err_seq), RESYNC. clr_err asserted the same cycle as a later error -> err_sticky stays 1.
- Reset during L2 -> outputs return to reset values asynchronously. After release, an immediate 001000 is accepted with no OFF dwell error.
